nfc_host_seq: RTL and testbench

Host-side command sequencer directly upstream of the NAND flash controller (nfc).
- Accepts one page-level request at a time: read, program, erase or reset.
- For program, loads the controller page buffer from a byte stream. For read, drains the buffer to a byte stream after the controller finishes.
- Issues nfc_cmd/nfc_strt, waits for nfc_done, and returns a status word with Perr/EErr/RErr and a timeout flag.

---
 rtl/nfc_pkg.sv | 40 ++++
 rtl/nfc_host_seq_if.sv | 25 ++
 rtl/nfc_wdog.sv | 29 ++
 rtl/nfc_host_seq.sv | 174 +++++++++++++++++
 tb/tb_nfc_host_seq.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nfc_pkg.sv
// Shared types and constants for the NAND host-side command sequencer.
package nfc_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_PROG  = 2'b01,
    OP_ERASE = 2'b10,
    OP_RESET = 2'b11
  } op_e;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_PROG  = 3'b010;
  localparam logic [2:0] CMD_ERASE = 3'b011;
  localparam logic [2:0] CMD_RST   = 3'b100;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    START,
    WAIT,
    DRAIN,
    RESP
  } state_e;

  // Bit positions inside rsp_status = {timeout, RErr, EErr, Perr}
  localparam int unsigned ST_PERR = 0;
  localparam int unsigned ST_EERR = 1;
  localparam int unsigned ST_RERR = 2;
  localparam int unsigned ST_TMO  = 3;

  function automatic logic [2:0] cmd_of(input op_e op);
    case (op)
      OP_READ:  return CMD_READ;
      OP_PROG:  return CMD_PROG;
      OP_ERASE: return CMD_ERASE;
      default:  return CMD_RST;
    endcase
  endfunction

endpackage

// File: rtl/nfc_host_seq_if.sv
// Host-facing request / write-stream / read-stream / response bundle.
interface nfc_host_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rsp_valid;
  logic [3:0]  rsp_status;

  modport master (
    output req_valid, req_op, req_addr, wr_data, wr_valid, rd_ready,
    input  req_ready, wr_ready, rd_data, rd_valid, rsp_valid, rsp_status
  );

  modport slave (
    input  req_valid, req_op, req_addr, wr_data, wr_valid, rd_ready,
    output req_ready, wr_ready, rd_data, rd_valid, rsp_valid, rsp_status
  );
endinterface

// File: rtl/nfc_wdog.sv
// Completion watchdog: cleared on command start, counts while enabled.
// TIMEOUT_CYC must be at least 2.
module nfc_wdog #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int unsigned   W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0]  CNT_MAX = W'(TIMEOUT_CYC - 1);
  localparam logic [W-1:0]  CNT_PRE = W'(TIMEOUT_CYC - 2);

  logic [W-1:0] cnt;

  // Saturating cycle counter; holds at TIMEOUT_CYC-1 rather than wrapping
  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en && cnt != CNT_MAX)
      cnt <= cnt + W'(1);
  end

  // Flags the enabled cycle whose increment makes the count reach TIMEOUT_CYC-1,
  // so the response lands exactly TIMEOUT_CYC cycles after the start pulse
  assign expire = en && (cnt == CNT_PRE);
endmodule

// File: rtl/nfc_host_seq.sv
// Host-side command sequencer in front of the NAND flash controller:
// fills the page buffer for program, starts the controller, waits for done
// (with watchdog), drains the buffer for read, and returns a status word.
module nfc_host_seq
  import nfc_pkg::*;
#(
  parameter int unsigned PAGE_BYTES  = 2048,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  nfc_host_seq_if.slave host,
  output logic         BF_Sel,
  output logic [10:0]  BF_ad,
  output logic [7:0]   BF_din,
  output logic         BF_we,
  input  logic [7:0]   BF_dou,
  output logic [15:0]  RWA,
  output logic [2:0]   nfc_cmd,
  output logic         nfc_strt,
  input  logic         nfc_done,
  input  logic         Perr,
  input  logic         EErr,
  input  logic         RErr
);
  localparam logic [10:0] LAST = 11'(PAGE_BYTES - 1);

  state_e      state, state_nx;
  op_e         op_q;
  logic [15:0] addr_q;
  logic [10:0] cnt;
  logic        pend;
  logic        rd_valid_q;
  logic [7:0]  rd_data_q;
  logic [3:0]  status_q;
  logic [3:0]  done_status;
  logic        expire;

  nfc_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == START),
    .en     (state == WAIT),
    .expire (expire)
  );

  // Controller error flags placed into the status word layout
  always_comb begin
    done_status          = '0;
    done_status[ST_PERR] = Perr;
    done_status[ST_EERR] = EErr;
    done_status[ST_RERR] = RErr;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and outputs; everything but req_ready is forced low during reset
  always_comb begin
    state_nx        = state;
    host.wr_ready   = 1'b0;
    host.rsp_valid  = 1'b0;
    host.rsp_status = '0;
    BF_Sel          = 1'b0;
    BF_ad           = '0;
    BF_din          = '0;
    BF_we           = 1'b0;
    RWA             = '0;
    nfc_cmd         = '0;
    nfc_strt        = 1'b0;
    host.req_ready  = (state == IDLE);
    if (!reset) begin
      case (state)
        IDLE: if (host.req_valid)
                state_nx = (op_e'(host.req_op) == OP_PROG) ? FILL : START;
        FILL: begin
          BF_Sel        = 1'b1;
          host.wr_ready = 1'b1;
          BF_ad         = cnt;
          if (host.wr_valid) begin
            BF_we  = 1'b1;
            BF_din = host.wr_data;
            if (cnt == LAST) state_nx = START;
          end
        end
        START: begin
          nfc_strt = 1'b1;
          nfc_cmd  = cmd_of(op_q);
          RWA      = addr_q;
          state_nx = WAIT;
        end
        WAIT: begin
          nfc_cmd = cmd_of(op_q);
          RWA     = addr_q;
          if (nfc_done)    state_nx = (op_q == OP_READ) ? DRAIN : RESP;
          else if (expire) state_nx = RESP;
        end
        DRAIN: begin
          nfc_cmd = cmd_of(op_q);
          RWA     = addr_q;
          BF_Sel  = 1'b1;
          // While a byte is on offer, pre-address the next one so its data
          // arrives the cycle after the host takes the current byte
          BF_ad   = rd_valid_q ? cnt + 11'd1 : cnt;
          if (rd_valid_q && host.rd_ready && cnt == LAST) state_nx = RESP;
        end
        RESP: begin
          nfc_cmd         = cmd_of(op_q);
          RWA             = addr_q;
          host.rsp_valid  = 1'b1;
          host.rsp_status = status_q;
          state_nx        = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Request latch, byte counter, status capture and read-stream registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_READ;
      addr_q     <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      status_q   <= '0;
    end else begin
      case (state)
        IDLE: if (host.req_valid) begin
          op_q     <= op_e'(host.req_op);
          addr_q   <= host.req_addr;
          cnt      <= '0;
          status_q <= '0;
        end
        FILL: if (host.wr_valid && cnt != LAST) cnt <= cnt + 11'd1;
        WAIT: begin
          if (nfc_done) begin
            status_q   <= done_status;
            cnt        <= '0;
            pend       <= 1'b0;
            rd_valid_q <= 1'b0;
          end else if (expire) begin
            status_q         <= '0;
            status_q[ST_TMO] <= 1'b1;
          end
        end
        DRAIN: begin
          if (pend) begin
            rd_data_q  <= BF_dou;
            rd_valid_q <= 1'b1;
            pend       <= 1'b0;
          end else if (!rd_valid_q) begin
            pend <= 1'b1;
          end else if (host.rd_ready) begin
            rd_valid_q <= 1'b0;
            if (cnt != LAST) begin
              cnt  <= cnt + 11'd1;
              pend <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign host.rd_valid = rd_valid_q & ~reset;
  assign host.rd_data  = reset ? '0 : rd_data_q;
endmodule

// File: tb/tb_nfc_host_seq.sv
// Self-checking bench for nfc_host_seq with a page-buffer model and an
// event monitor that scores transactions at the host/controller level.
module tb_nfc_host_seq;
  import nfc_pkg::*;

  localparam int unsigned PAGE = 2048;
  localparam int unsigned TMO  = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nfc_host_seq_if host ();
  logic        BF_Sel, BF_we;
  logic [10:0] BF_ad;
  logic [7:0]  BF_din;
  logic [7:0]  BF_dou = 8'h00;
  logic [15:0] RWA;
  logic [2:0]  nfc_cmd;
  logic        nfc_strt;
  logic        nfc_done = 1'b0, Perr = 1'b0, EErr = 1'b0, RErr = 1'b0;

  nfc_host_seq #(.PAGE_BYTES(PAGE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .host(host),
    .BF_Sel(BF_Sel), .BF_ad(BF_ad), .BF_din(BF_din), .BF_we(BF_we), .BF_dou(BF_dou),
    .RWA(RWA), .nfc_cmd(nfc_cmd), .nfc_strt(nfc_strt), .nfc_done(nfc_done),
    .Perr(Perr), .EErr(EErr), .RErr(RErr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Page buffer: synchronous write, registered read
  logic [7:0] mem [PAGE];
  always @(posedge clk) begin
    if (BF_Sel && BF_we) mem[BF_ad] <= BF_din;
    BF_dou <= (BF_Sel && !BF_we) ? mem[BF_ad] : 8'h00;
  end

  // Monitor state
  int strt_total = 0, op_strt = 0, strt_cyc = 0;
  int op_we = 0, we_err = 0, op_rd = 0, rd_err = 0, stab_err = 0, rdv_seen = 0;
  int rsp_cnt = 0, rsp_cyc = 0, rd_at_rsp = 0, cmd_early = 0, ready_err = 0;
  logic [2:0]  strt_cmd = '0;
  logic [15:0] strt_rwa = '0;
  logic [3:0]  rsp_stat = '0;
  logic [1:0]  cur_op = '0;
  logic        rd_hold = 1'b0;
  logic [7:0]  rd_last = '0;
  bit          busy = 1'b0;
  int          acc_q[$];
  int          rsp_q[$];

  always @(negedge clk) begin
    if (reset) begin
      rd_hold = 1'b0;
      busy    = 1'b0;
    end else begin
      if (busy && host.req_ready) ready_err++;
      if (host.req_valid && host.req_ready) begin
        acc_q.push_back(cyc);
        cur_op = host.req_op;
        op_strt = 0; op_we = 0; op_rd = 0; rdv_seen = 0;
        busy = 1'b1;
      end
      if (host.rsp_valid) begin
        rsp_cnt++; rsp_cyc = cyc; rsp_stat = host.rsp_status; rd_at_rsp = op_rd;
        rsp_q.push_back(cyc);
        busy = 1'b0;
      end
      if (nfc_strt) begin
        strt_total++; op_strt++; strt_cyc = cyc; strt_cmd = nfc_cmd; strt_rwa = RWA;
      end
      if (nfc_cmd != 3'd0 && cur_op == 2'b01 && op_we < PAGE) cmd_early++;
      if (BF_we) begin
        if (!BF_Sel || BF_ad != op_we[10:0] || BF_din != op_we[7:0]) we_err++;
        op_we++;
      end
      if (rd_hold && (!host.rd_valid || host.rd_data != rd_last)) stab_err++;
      if (host.rd_valid) rdv_seen++;
      if (host.rd_valid && host.rd_ready) begin
        if (host.rd_data != (8'hA5 ^ op_rd[7:0])) rd_err++;
        op_rd++;
      end
      rd_hold = host.rd_valid && !host.rd_ready;
      rd_last = host.rd_data;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_cmd(input int op);
    case (op)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  task automatic preload();
    for (int i = 0; i < PAGE; i++) mem[i] = 8'hA5 ^ i[7:0];
  endtask

  task automatic send_req(input int op, input logic [15:0] addr, output bit ok);
    int g = 0;
    bit acc = 1'b0;
    host.req_valid = 1'b1; host.req_op = op[1:0]; host.req_addr = addr;
    while (!acc && g < 50) begin
      @(negedge clk); acc = host.req_ready;
      @(posedge clk); #1; g++;
    end
    host.req_valid = 1'b0;
    ok = acc;
  endtask

  task automatic respond(input int base, input int dly, input logic p, input logic e,
                         input logic r, output bit ok);
    int g = 0;
    while (strt_total == base && g < 200) begin @(posedge clk); #1; g++; end
    ok = (strt_total != base);
    if (ok) begin
      repeat (dly) @(posedge clk);
      #1;
      nfc_done = 1'b1; Perr = p; EErr = e; RErr = r;
      @(posedge clk); #1;
      nfc_done = 1'b0; Perr = 1'b0; EErr = 1'b0; RErr = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int base, input int budget, output bit ok);
    int g = 0;
    while (rsp_cnt == base && g < budget) begin @(posedge clk); #1; g++; end
    ok = (rsp_cnt != base);
  endtask

  task automatic drive_bytes(input int n, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        host.wr_valid = 1'b0; @(posedge clk); #1;
      end
      host.wr_valid = 1'b1; host.wr_data = i[7:0];
      @(negedge clk); if (!host.wr_ready) ok = 1'b0;
      @(posedge clk); #1;
    end
    host.wr_valid = 1'b0;
  endtask

  task automatic run_simple(input int op, input logic [15:0] addr, input int dly,
                            input logic p, input logic e, input logic r);
    int s0 = strt_total, r0 = rsp_cnt;
    bit ok;
    send_req(op, addr, ok);           check("simple_accept", ok, 1);
    respond(s0, dly, p, e, r, ok);    check("simple_strt_seen", ok, 1);
    wait_rsp(r0, 200, ok);            check("simple_rsp_seen", ok, 1);
    check("simple_strt_cnt", op_strt, 1);
    check("simple_cmd", strt_cmd, exp_cmd(op));
    check("simple_rwa", strt_rwa, addr);
    check("simple_status", rsp_stat, {1'b0, r, e, p});
  endtask

  task automatic run_program();
    int s0 = strt_total, r0 = rsp_cnt;
    logic [15:0] addr = 16'($urandom);
    bit ok;
    send_req(1, addr, ok);     check("prog_accept", ok, 1);
    drive_bytes(PAGE, ok);     check("prog_wr_ready", ok, 1);
    host.wr_valid = 1'b1; host.wr_data = 8'hEE;  // must be ignored outside FILL
    respond(s0, $urandom_range(0, 40), 1'b1, 1'b0, 1'b0, ok);
    check("prog_strt_seen", ok, 1);
    wait_rsp(r0, 200, ok);     check("prog_rsp_seen", ok, 1);
    host.wr_valid = 1'b0;
    check("prog_we_count", op_we, PAGE);
    check("prog_we_order", we_err, 0);
    check("prog_cmd_early", cmd_early, 0);
    check("prog_strt_cnt", op_strt, 1);
    check("prog_cmd", strt_cmd, 2);
    check("prog_rwa", strt_rwa, addr);
    check("prog_status", rsp_stat, 4'b0001);
  endtask

  task automatic run_read(input string pfx);
    int s0 = strt_total, r0 = rsp_cnt;
    logic [15:0] addr = 16'($urandom);
    logic rr = 1'($urandom);
    bit ok, ok1;
    preload();
    send_req(0, addr, ok);     check({pfx, "_accept"}, ok, 1);
    fork
      respond(s0, $urandom_range(0, 40), 1'b0, 1'b0, rr, ok1);
      begin
        int g = 0;
        while (rsp_cnt == r0 && g < 20000) begin
          @(posedge clk); #1; host.rd_ready = 1'($urandom); g++;
        end
        host.rd_ready = 1'b0;
      end
    join
    check({pfx, "_strt_seen"}, ok1, 1);
    check({pfx, "_rsp_seen"}, rsp_cnt - r0, 1);
    check({pfx, "_rd_count"}, op_rd, PAGE);
    check({pfx, "_rd_data"}, rd_err, 0);
    check({pfx, "_rd_stable"}, stab_err, 0);
    check({pfx, "_rsp_after_last"}, rd_at_rsp, PAGE);
    check({pfx, "_no_write"}, op_we, 0);
    check({pfx, "_cmd"}, strt_cmd, 1);
    check({pfx, "_rwa"}, strt_rwa, addr);
    check({pfx, "_status"}, rsp_stat, {1'b0, rr, 2'b00});
  endtask

  task automatic run_timeout(input int op);
    int r0 = rsp_cnt;
    bit ok;
    send_req(op, 16'($urandom), ok);  check("tmo_accept", ok, 1);
    wait_rsp(r0, 400, ok);            check("tmo_rsp_seen", ok, 1);
    check("tmo_strt_cnt", op_strt, 1);
    check("tmo_latency", rsp_cyc - strt_cyc, TMO);
    check("tmo_status", rsp_stat, 4'b1000);
    check("tmo_no_drain", rdv_seen, 0);
  endtask

  task automatic run_reset_start();
    int s0 = strt_total, r0 = rsp_cnt;
    bit ok;
    send_req(2, 16'h0BAD, ok);        check("rst_start_accept", ok, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_start_strt", nfc_strt, 0);
    check("rst_start_ready", host.req_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check("rst_start_no_strt", strt_total - s0, 0);
    check("rst_start_no_rsp", rsp_cnt - r0, 0);
  endtask

  task automatic run_reset_fill();
    int s0 = strt_total, r0 = rsp_cnt;
    bit ok;
    send_req(1, 16'h4444, ok);        check("rst_fill_accept", ok, 1);
    drive_bytes(10, ok);              check("rst_fill_wr_ready", ok, 1);
    check("rst_fill_bytes", op_we, 10);
    host.wr_valid = 1'b1; host.wr_data = 8'h77;
    reset = 1'b1;
    @(negedge clk);
    check("rst_fill_we", BF_we, 0);
    check("rst_fill_wr_ready_low", host.wr_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0; host.wr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_fill_no_strt", strt_total - s0, 0);
    check("rst_fill_no_rsp", rsp_cnt - r0, 0);
    run_read("rst_read");
  endtask

  task automatic run_b2b();
    int a0 = acc_q.size(), r0 = rsp_cnt, s0 = strt_total;
    bit ok1, ok2, ok;
    host.req_valid = 1'b1; host.req_op = 2'b11; host.req_addr = 16'h00AA;
    fork
      begin
        respond(s0, $urandom_range(0, 20), 1'b0, 1'b0, 1'b0, ok1);
        respond(s0 + 1, $urandom_range(0, 20), 1'b0, 1'b0, 1'b0, ok2);
      end
      begin
        int g = 0;
        while (acc_q.size() < a0 + 2 && g < 500) begin @(posedge clk); #1; g++; end
        host.req_valid = 1'b0;
      end
    join
    wait_rsp(r0 + 1, 200, ok);
    check("b2b_strt1", ok1, 1);
    check("b2b_strt2", ok2, 1);
    check("b2b_accepts", acc_q.size() - a0, 2);
    check("b2b_rsps", rsp_cnt - r0, 2);
    if (acc_q.size() >= a0 + 2 && rsp_q.size() >= r0 + 1)
      check("b2b_accept_after_rsp", acc_q[a0 + 1] - rsp_q[r0], 1);
    else
      check("b2b_accept_after_rsp", -1, 1);
    check("b2b_ready_low_busy", ready_err, 0);
    check("b2b_cmd", strt_cmd, 4);
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time budget exhausted");
  end

  initial begin
    host.req_valid = 1'b0; host.req_op = '0; host.req_addr = '0;
    host.wr_valid = 1'b0; host.wr_data = '0; host.rd_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", host.req_ready, 1);
    check("reset_strt", nfc_strt, 0);
    check("reset_rsp_valid", host.rsp_valid, 0);
    check("reset_bf_sel", BF_Sel, 0);
    check("reset_wr_ready", host.wr_ready, 0);
    check("reset_rd_valid", host.rd_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", host.req_ready, 1);
    check("idle_cmd", nfc_cmd, 0);
    @(posedge clk); #1;

    run_simple(2, 16'h0123, 50, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      run_simple($urandom_range(2, 3), 16'($urandom), $urandom_range(0, 80),
                 1'($urandom), 1'($urandom), 1'($urandom));
    run_program();
    run_read("read");
    run_timeout(2);
    run_timeout(0);
    run_reset_start();
    run_reset_fill();
    run_b2b();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
